// File: rtl/neurocore_pkg.sv
// Shared parameters and state encoding for the neurocore datapath.
package neurocore_pkg;

    localparam int unsigned DATA_W = 16;  // element width
    localparam int unsigned J      = 2;   // block rows
    localparam int unsigned K      = 2;   // block columns
    localparam int unsigned ADDR_W = 10;  // memory address width
    localparam int unsigned CALC_W = 21;  // full-width address arithmetic

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } put_state_e;

endpackage

// File: rtl/block_addr_calc.sv
// Maps a block element index to its destination address and bounds flag.
// Purely combinational so both the put and fetch stages can share it.
module block_addr_calc #(
    parameter int unsigned K     = neurocore_pkg::K,
    parameter int unsigned IDX_W = 2
) (
    input  logic [IDX_W-1:0]                 elem_idx,
    input  logic [neurocore_pkg::ADDR_W-1:0] start_row,
    input  logic [neurocore_pkg::ADDR_W-1:0] start_col,
    input  logic [neurocore_pkg::ADDR_W-1:0] num_cols,
    input  logic [neurocore_pkg::ADDR_W-1:0] matrix_len,
    output logic [neurocore_pkg::ADDR_W-1:0] elem_addr,
    output logic                             in_bounds
);
    import neurocore_pkg::*;

    logic [31:0]       elem_w;
    logic [31:0]       row_off;
    logic [31:0]       col_off;
    logic [CALC_W-1:0] row_sum;
    logic [CALC_W-1:0] col_sum;
    logic [CALC_W-1:0] addr_full;

    // Row-major split and untruncated address; bounds use the full width
    always_comb begin
        elem_w    = 32'(elem_idx);
        row_off   = elem_w / K;
        col_off   = elem_w % K;
        row_sum   = CALC_W'(start_row) + CALC_W'(row_off);
        col_sum   = CALC_W'(start_col) + CALC_W'(col_off);
        addr_full = row_sum * CALC_W'(num_cols) + col_sum;
        in_bounds = (col_sum < CALC_W'(num_cols)) && (addr_full < CALC_W'(matrix_len));
        elem_addr = addr_full[ADDR_W-1:0];
    end

endmodule

// File: rtl/block_put.sv
// Writes a JxK result block back to memory, either overwriting or
// read-modify-write accumulating each in-bounds element.
module block_put #(
    parameter int unsigned DATA_W = neurocore_pkg::DATA_W,
    parameter int unsigned J      = neurocore_pkg::J,
    parameter int unsigned K      = neurocore_pkg::K
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             accumulate,
    input  logic [neurocore_pkg::ADDR_W-1:0] start_row,
    input  logic [neurocore_pkg::ADDR_W-1:0] start_col,
    input  logic [neurocore_pkg::ADDR_W-1:0] num_cols,
    input  logic [neurocore_pkg::ADDR_W-1:0] matrix_len,
    input  logic [DATA_W-1:0]                block [0:J*K-1],
    output logic [neurocore_pkg::ADDR_W-1:0] mem_addr,
    output logic                             mem_re,
    output logic                             mem_we,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata,
    output logic                             busy,
    output logic                             block_put_done
);
    import neurocore_pkg::*;

    localparam int unsigned NUM_ELEM = J * K;
    localparam int unsigned IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    put_state_e        state_q, state_d;
    logic [IDX_W-1:0]  e_q, e_d;
    logic              load;

    logic              acc_q;
    logic [ADDR_W-1:0] start_row_q, start_col_q, num_cols_q, matrix_len_q;
    logic [DATA_W-1:0] block_q [0:J*K-1];

    logic [ADDR_W-1:0] elem_addr;
    logic              in_bounds;

    block_addr_calc #(
        .K     (K),
        .IDX_W (IDX_W)
    ) u_addr_calc (
        .elem_idx   (e_q),
        .start_row  (start_row_q),
        .start_col  (start_col_q),
        .num_cols   (num_cols_q),
        .matrix_len (matrix_len_q),
        .elem_addr  (elem_addr),
        .in_bounds  (in_bounds)
    );

    // State and element index; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            e_q     <= '0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
        end
    end

    // Operand capture when a start is accepted; later input changes are ignored
    always_ff @(posedge clk) begin
        if (load) begin
            acc_q        <= accumulate;
            start_row_q  <= start_row;
            start_col_q  <= start_col;
            num_cols_q   <= num_cols;
            matrix_len_q <= matrix_len;
            for (int i = 0; i < int'(NUM_ELEM); i++) begin
                block_q[i] <= block[i];
            end
        end
    end

    // Next-state and memory strobes; address/data stay 0 unless strobed
    always_comb begin
        state_d        = state_q;
        e_d            = e_q;
        load           = 1'b0;
        mem_re         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        block_put_done = 1'b0;
        busy           = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (start && !rst) begin
                    load    = 1'b1;
                    e_d     = '0;
                    state_d = accumulate ? StRead : StWrite;
                end
            end
            StRead: begin
                if (in_bounds) begin
                    mem_re   = 1'b1;
                    mem_addr = elem_addr;
                    state_d  = StWrite;
                end else if (e_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    e_d = e_q + IDX_W'(1);
                end
            end
            StWrite: begin
                // In accumulate mode this state is only entered for in-bounds elements
                if (in_bounds) begin
                    mem_we    = 1'b1;
                    mem_addr  = elem_addr;
                    mem_wdata = acc_q ? (mem_rdata + block_q[e_q]) : block_q[e_q];
                end
                if (e_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    e_d     = e_q + IDX_W'(1);
                    state_d = acc_q ? StRead : StWrite;
                end
            end
            StDone: begin
                block_put_done = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_block_put.sv
// Randomized self-checking bench for block_put against a cycle-level
// reference built directly from the block write-back rules.
module tb_block_put;
    import neurocore_pkg::*;

    localparam int unsigned NE = J * K;

    logic              clk = 1'b0;
    logic              rst, start, accumulate;
    logic [9:0]        start_row, start_col, num_cols, matrix_len;
    logic [DATA_W-1:0] block [0:J*K-1];
    logic [9:0]        mem_addr;
    logic              mem_re, mem_we;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy, block_put_done;

    // Backing memory plus a preload port used only by the bench
    logic [DATA_W-1:0] mem     [0:1023];
    logic [DATA_W-1:0] ref_mem [0:1023];
    logic              ld_en;
    logic [9:0]        ld_addr;
    logic [DATA_W-1:0] ld_data;

    int checks = 0;
    int errors = 0;
    int opn    = 0;

    typedef struct {
        bit re;
        bit we;
        int addr;
        int wdata;
        bit busy;
        bit done;
    } exp_t;

    block_put #(
        .DATA_W (DATA_W),
        .J      (J),
        .K      (K)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .accumulate     (accumulate),
        .start_row      (start_row),
        .start_col      (start_col),
        .num_cols       (num_cols),
        .matrix_len     (matrix_len),
        .block          (block),
        .mem_addr       (mem_addr),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .block_put_done (block_put_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mem_load(input int a, input logic [DATA_W-1:0] d);
        ld_en   = 1'b1;
        ld_addr = 10'(a);
        ld_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(block_put_done), 0);
        check({tag, " re"}, 32'(mem_re), 0);
        check({tag, " we"}, 32'(mem_we), 0);
        check({tag, " addr"}, 32'(mem_addr), 0);
        check({tag, " wdata"}, 32'(mem_wdata), 0);
    endtask

    // One complete operation; pester re-pulses start and scrambles inputs while busy
    task automatic run_op(input bit acc, input int sr, input int sc, input int nc, input int ml,
                          input logic [DATA_W-1:0] blk [0:J*K-1], input bit pester);
        exp_t q[$];
        exp_t r;
        int   i, j, a, n;
        logic [DATA_W-1:0] sum;
        string tag;

        opn++;
        for (int e = 0; e < int'(NE); e++) begin
            i = e / int'(K);
            j = e % int'(K);
            a = (sr + i) * nc + sc + j;
            if ((sc + j) < nc && a < ml) begin
                if (acc) begin
                    r = '{re: 1, we: 0, addr: a, wdata: 0, busy: 1, done: 0};
                    q.push_back(r);
                    sum = ref_mem[a] + blk[e];
                end else begin
                    sum = blk[e];
                end
                ref_mem[a] = sum;
                r = '{re: 0, we: 1, addr: a, wdata: int'(sum), busy: 1, done: 0};
                q.push_back(r);
            end else begin
                r = '{re: 0, we: 0, addr: 0, wdata: 0, busy: 1, done: 0};
                q.push_back(r);
            end
        end
        r = '{re: 0, we: 0, addr: 0, wdata: 0, busy: 1, done: 1};
        q.push_back(r);
        n = q.size();

        start      = 1'b1;
        accumulate = acc;
        start_row  = 10'(sr);
        start_col  = 10'(sc);
        num_cols   = 10'(nc);
        matrix_len = 10'(ml);
        block      = blk;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tag = $sformatf("op%0d c%0d", opn, c + 1);
            check({tag, " re"}, 32'(mem_re), 32'(q[c].re));
            check({tag, " we"}, 32'(mem_we), 32'(q[c].we));
            check({tag, " addr"}, 32'(mem_addr), 32'(q[c].addr));
            check({tag, " wdata"}, 32'(mem_wdata), 32'(q[c].wdata));
            check({tag, " busy"}, 32'(busy), 32'(q[c].busy));
            check({tag, " done"}, 32'(block_put_done), 32'(q[c].done));
            if (pester && (c + 1) < n) begin
                start      = ((c + 1) == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                accumulate = 1'($urandom_range(0, 1));
                start_row  = 10'($urandom);
                start_col  = 10'($urandom);
                num_cols   = 10'($urandom);
                matrix_len = 10'($urandom);
                for (int k = 0; k < int'(NE); k++) block[k] = DATA_W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check_idle($sformatf("op%0d after", opn));
        foreach (q[c]) begin
            if (q[c].we) begin
                check($sformatf("op%0d mem[%0d]", opn, q[c].addr), 32'(mem[q[c].addr]),
                      32'(ref_mem[q[c].addr]));
            end
        end
    endtask

    initial begin
        logic [DATA_W-1:0] blk [0:J*K-1];
        int sr, sc, nc, ml;
        bit big;

        rst = 1'b1;
        start = 1'b0;
        accumulate = 1'b0;
        start_row = '0;
        start_col = '0;
        num_cols = '0;
        matrix_len = '0;
        for (int k = 0; k < int'(NE); k++) block[k] = '0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;

        @(negedge clk);
        for (int a = 0; a < 1024; a++) mem_load(a, DATA_W'($urandom));
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post-reset");

        // Plain overwrite into the interior of a 4x4 matrix
        blk = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_op(0, 1, 1, 4, 16, blk, 0);
        // Corner clip: only the top-left element lands
        blk = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};
        run_op(0, 3, 3, 4, 16, blk, 0);
        // Accumulate with wrap-around
        mem_load(0, 16'hFFFF);
        blk = '{16'd2, 16'd7, 16'd9, 16'd11};
        run_op(1, 0, 0, 4, 16, blk, 0);
        // Start re-pulsed and inputs scrambled while busy
        blk = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        run_op(0, 1, 1, 4, 16, blk, 1);
        // Zero row width and zero length: nothing in bounds
        run_op(0, 0, 0, 0, 16, blk, 0);
        run_op(1, 0, 0, 4, 0, blk, 0);

        // Reset mid-operation: two writes land, then nothing
        blk = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        start = 1'b1;
        accumulate = 1'b0;
        start_row = 10'd1;
        start_col = 10'd1;
        num_cols = 10'd4;
        matrix_len = 10'd16;
        block = blk;
        @(negedge clk);
        start = 1'b0;
        check("abort c1 we", 32'(mem_we), 1);
        check("abort c1 addr", 32'(mem_addr), 5);
        ref_mem[5] = blk[0];
        @(negedge clk);
        check("abort c2 we", 32'(mem_we), 1);
        check("abort c2 addr", 32'(mem_addr), 6);
        ref_mem[6] = blk[1];
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort c3");
        start = 1'b1;
        @(negedge clk);
        check_idle("abort c4");
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("abort c5");
        check("abort mem[5]", 32'(mem[5]), 32'(ref_mem[5]));
        check("abort mem[6]", 32'(mem[6]), 32'(ref_mem[6]));
        check("abort mem[9]", 32'(mem[9]), 32'(ref_mem[9]));
        run_op(0, 1, 1, 4, 16, blk, 0);

        // Randomized operations, including huge coordinates that overflow 10 bits
        for (int t = 0; t < 60; t++) begin
            big = ($urandom_range(0, 7) == 0);
            sr = big ? $urandom_range(900, 1023) : $urandom_range(0, 7);
            sc = big ? $urandom_range(900, 1023) : $urandom_range(0, 7);
            nc = big ? $urandom_range(900, 1023) : $urandom_range(0, 9);
            ml = big ? $urandom_range(900, 1023) : $urandom_range(0, 80);
            for (int k = 0; k < int'(NE); k++) blk[k] = DATA_W'($urandom);
            run_op(1'($urandom_range(0, 1)), sr, sc, nc, ml, blk, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
